dmem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the byte-wide data memory. It grants the shared memory port round-robin between requester 0 (core load/store path) and requester 1 (loader/DMA path). It splits each byte, half or word access into little-endian byte beats and returns sign- or zero-extended load data. It sits between the requesters and the data memory's write-enable/address/data ports.

---
 rtl/dmem_port_arbiter_if.sv | 55 +++++
 rtl/dmem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Requester and byte-wide memory port bundle for dmem_port_arbiter; err ports exist only with DMEM_ARB_ALIGN_CHECK_EN.
// The arbiter takes the slave modport; the requesters plus memory take the master modport.
interface dmem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req0_i;
    logic                     we0_i;
    logic [1:0]               size0_i;
    logic                     uns0_i;
    logic [ADDRESS_WIDTH-1:0] addr0_i;
    logic [DATA_WIDTH-1:0]    wdata0_i;
    logic                     ack0_o;
    logic [DATA_WIDTH-1:0]    rdata0_o;

    logic                     req1_i;
    logic                     we1_i;
    logic [1:0]               size1_i;
    logic                     uns1_i;
    logic [ADDRESS_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0]    wdata1_i;
    logic                     ack1_o;
    logic [DATA_WIDTH-1:0]    rdata1_o;

    logic                     mem_wr_en_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [7:0]               mem_data_o;
    logic [7:0]               mem_data_i;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic                     err0_o;
    logic                     err1_o;
`endif

    modport slave (
        input  req0_i, we0_i, size0_i, uns0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, size1_i, uns1_i, addr1_i, wdata1_i,
        input  mem_data_i,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        output err0_o, err1_o,
`endif
        output ack0_o, rdata0_o, ack1_o, rdata1_o,
        output mem_wr_en_o, mem_addr_o, mem_data_o
    );

    modport master (
        output req0_i, we0_i, size0_i, uns0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, size1_i, uns1_i, addr1_i, wdata1_i,
        output mem_data_i,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        input  err0_o, err1_o,
`endif
        input  ack0_o, rdata0_o, ack1_o, rdata1_o,
        input  mem_wr_en_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter splitting byte/half/word accesses into byte beats; optional DMEM_ARB_ALIGN_CHECK_EN.
// Ack after n+1 (store) / n+2 (load) cycles; a losing request is held off, never dropped.
module dmem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, gnt_q, we_q, uns_q, err_q;
    logic [1:0]               size_q, beat_q, last_beat;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rbuf_q, ext;

    logic                     any_req, sel, sel_we, sel_uns, sel_mis;
    logic [1:0]               sel_size;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     live, in_xfer, resp, ld_resp, wr_en;

    assign any_req   = bus.req0_i | bus.req1_i;
    assign sel       = (bus.req0_i & bus.req1_i) ? ~last_q : bus.req1_i;
    assign sel_we    = sel ? bus.we1_i    : bus.we0_i;
    assign sel_size  = sel ? bus.size1_i  : bus.size0_i;
    assign sel_uns   = sel ? bus.uns1_i   : bus.uns0_i;
    assign sel_addr  = sel ? bus.addr1_i  : bus.addr0_i;
    assign sel_wdata = sel ? bus.wdata1_i : bus.wdata0_i;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    // Size 11 runs as a word, so it is checked as one.
    assign sel_mis = ((sel_size == 2'b01) && sel_addr[0]) ||
                     (sel_size[1] && (sel_addr[1:0] != 2'b00));
`else
    assign sel_mis = 1'b0;
`endif

    always_comb begin
        last_beat = 2'd3;
        case (size_q)
            2'b00:   last_beat = 2'd0;
            2'b01:   last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = sel_mis ? RESP : XFER;
            XFER:    if (beat_q == last_beat) state_d = we_q ? RESP : DRAIN;
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            beat_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    gnt_q   <= sel;
                    we_q    <= sel_we;
                    uns_q   <= sel_uns;
                    err_q   <= sel_mis;
                    size_q  <= sel_size;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    beat_q  <= 2'd0;
                    rbuf_q  <= '0;
                end
                XFER: begin
                    beat_q <= beat_q + 2'd1;
                    // Read data trails the address by one cycle.
                    if (!we_q && (beat_q != 2'd0))
                        rbuf_q[{beat_q - 2'd1, 3'b000} +: 8] <= bus.mem_data_i;
                end
                DRAIN:   rbuf_q[{last_beat, 3'b000} +: 8] <= bus.mem_data_i;
                RESP:    last_q <= gnt_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        ext = rbuf_q;
        case (size_q)
            2'b00:   ext = {{(DATA_WIDTH-8){~uns_q & rbuf_q[7]}},   rbuf_q[7:0]};
            2'b01:   ext = {{(DATA_WIDTH-16){~uns_q & rbuf_q[15]}}, rbuf_q[15:0]};
            default: ext = rbuf_q;
        endcase
    end

    // Reset also masks outputs combinationally so an interrupted beat never reaches memory.
    assign live    = ~rst_i;
    assign in_xfer = live && (state_q == XFER);
    assign wr_en   = in_xfer && we_q;
    assign resp    = live && (state_q == RESP);
    assign ld_resp = resp && !we_q && !err_q;

    assign bus.mem_wr_en_o = wr_en;
    assign bus.mem_addr_o  = in_xfer ? addr_q + ADDRESS_WIDTH'(beat_q) : '0;
    assign bus.mem_data_o  = wr_en ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;

    assign bus.ack0_o   = resp && !gnt_q;
    assign bus.ack1_o   = resp &&  gnt_q;
    assign bus.rdata0_o = (ld_resp && !gnt_q) ? ext : '0;
    assign bus.rdata1_o = (ld_resp &&  gnt_q) ? ext : '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bus.err0_o   = resp && err_q && !gnt_q;
    assign bus.err1_o   = resp && err_q &&  gnt_q;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-level arbitration and memory model.
module tb_dmem_port_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    dmem_port_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
    dmem_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct { logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata; } op_t;
    typedef struct { int unsigned c; logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct { int unsigned c; int unsigned g; bit p; logic [31:0] rd; logic er; } ev_t;

    int n_chk = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    int unsigned scn_t0;
    bit last_model;

    logic [7:0] mem_arr [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_q;
    wr_t wlog[$], exp_w[$];
    ev_t exp_ev[$], got_ev[$];
    op_t q0[$], q1[$];

    assign bus.mem_data_i = rd_q;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (bus.mem_wr_en_o) mem_arr[bus.mem_addr_o[7:0]] <= bus.mem_data_o;
        rd_q <= mem_arr[bus.mem_addr_o[7:0]];
    end

    always @(negedge clk_i)
        if (bus.mem_wr_en_o) wlog.push_back('{cyc, bus.mem_addr_o, bus.mem_data_o});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal(input op_t o);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        return (o.addr % 32'(nbytes(o.size))) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.size  = 2'($urandom_range(0, 3));
        o.uns   = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 1) == 1) ? (32'h0001_0000 + 32'($urandom_range(0, 255))) : $urandom();
        o.wdata = $urandom();
        return o;
    endfunction

    task automatic present(input bit p, input op_t o);
        if (p) begin
            bus.req1_i = 1'b1; bus.we1_i = o.we; bus.size1_i = o.size;
            bus.uns1_i = o.uns; bus.addr1_i = o.addr; bus.wdata1_i = o.wdata;
        end else begin
            bus.req0_i = 1'b1; bus.we0_i = o.we; bus.size0_i = o.size;
            bus.uns0_i = o.uns; bus.addr0_i = o.addr; bus.wdata0_i = o.wdata;
        end
    endtask

    task automatic scramble(input bit p);
        present(p, rand_op());
    endtask

    // One access at transaction level: memory effect, result, and the cycle it completes.
    task automatic model_op(input op_t o, input bit p, inout int unsigned t);
        int n, lat;
        logic [31:0] a, rd;
        longint unsigned v;
        n = nbytes(o.size);
        rd = '0;
        v = 0;
        if (misal(o)) lat = 1;
        else if (o.we) begin
            lat = n + 1;
            for (int i = 0; i < n; i++) begin
                a = o.addr + 32'(i);
                ref_mem[a[7:0]] = o.wdata[8*i +: 8];
                exp_w.push_back('{t + 1 + 32'(i), a, o.wdata[8*i +: 8]});
            end
        end else begin
            lat = n + 2;
            for (int i = 0; i < n; i++) begin
                a = o.addr + 32'(i);
                v = v + (longint'(ref_mem[a[7:0]]) << (8*i));
            end
            if (!o.uns && n < 4 && v >= (64'd1 << (8*n - 1)))
                v = v + (64'd1 << 32) - (64'd1 << (8*n));
            rd = v[31:0];
        end
        exp_ev.push_back('{t + 32'(lat), t, p, rd, misal(o)});
        last_model = p;
        t = t + 32'(lat) + 1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_i = 1'b0;
        last_model = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"},  32'(bus.ack0_o), 0);
        check({tag, "_ack1"},  32'(bus.ack1_o), 0);
        check({tag, "_rd0"},   bus.rdata0_o, 0);
        check({tag, "_rd1"},   bus.rdata1_o, 0);
        check({tag, "_wren"},  32'(bus.mem_wr_en_o), 0);
        check({tag, "_maddr"}, bus.mem_addr_o, 0);
        check({tag, "_mdata"}, 32'(bus.mem_data_o), 0);
    endtask

    // Each port presents its queue back to back, holding req until the queue drains.
    task automatic run_scn(input string tag);
        int unsigned t;
        int i0, i1, j0, j1, budget;
        bit p, leak;
        exp_ev.delete(); exp_w.delete(); got_ev.delete(); wlog.delete();
        scn_t0 = cyc;
        t = cyc;
        i0 = 0; i1 = 0;
        while (i0 < q0.size() || i1 < q1.size()) begin
            if (i0 < q0.size() && i1 < q1.size()) p = ~last_model;
            else p = (i0 >= q0.size());
            if (p) begin model_op(q1[i1], 1'b1, t); i1++; end
            else   begin model_op(q0[i0], 1'b0, t); i0++; end
        end
        j0 = 0; j1 = 0; leak = 1'b0;
        if (q0.size() > 0) present(1'b0, q0[0]);
        if (q1.size() > 0) present(1'b1, q1[0]);
        budget = int'(t - scn_t0) + 20;
        for (int k = 0; k < budget && got_ev.size() < exp_ev.size(); k++) begin
            @(posedge clk_i); #1;
            foreach (exp_ev[e])
                if (cyc == exp_ev[e].g + 1 && cyc < exp_ev[e].c) scramble(exp_ev[e].p);
            if (bus.ack0_o) begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                got_ev.push_back('{cyc, 0, 1'b0, bus.rdata0_o, bus.err0_o});
`else
                got_ev.push_back('{cyc, 0, 1'b0, bus.rdata0_o, 1'b0});
`endif
                j0++;
                if (j0 < q0.size()) present(1'b0, q0[j0]); else bus.req0_i = 1'b0;
            end else if (bus.rdata0_o != 0) leak = 1'b1;
            if (bus.ack1_o) begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                got_ev.push_back('{cyc, 0, 1'b1, bus.rdata1_o, bus.err1_o});
`else
                got_ev.push_back('{cyc, 0, 1'b1, bus.rdata1_o, 1'b0});
`endif
                j1++;
                if (j1 < q1.size()) present(1'b1, q1[j1]); else bus.req1_i = 1'b0;
            end else if (bus.rdata1_o != 0) leak = 1'b1;
        end
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        check({tag, "_nack"}, got_ev.size(), exp_ev.size());
        foreach (exp_ev[e]) if (e < got_ev.size()) begin
            check($sformatf("%s_cyc%0d", tag, e), got_ev[e].c - scn_t0, exp_ev[e].c - scn_t0);
            check($sformatf("%s_port%0d", tag, e), 32'(got_ev[e].p), 32'(exp_ev[e].p));
            check($sformatf("%s_rdata%0d", tag, e), got_ev[e].rd, exp_ev[e].rd);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            check($sformatf("%s_err%0d", tag, e), 32'(got_ev[e].er), 32'(exp_ev[e].er));
`endif
        end
        check({tag, "_nwr"}, wlog.size(), exp_w.size());
        foreach (exp_w[w]) if (w < wlog.size()) begin
            check($sformatf("%s_wcyc%0d", tag, w), wlog[w].c - scn_t0, exp_w[w].c - scn_t0);
            check($sformatf("%s_waddr%0d", tag, w), wlog[w].a, exp_w[w].a);
            check($sformatf("%s_wdata%0d", tag, w), 32'(wlog[w].d), 32'(exp_w[w].d));
        end
        check({tag, "_rd_idle"}, 32'(leak), 0);
        if (got_ev.size() != exp_ev.size()) do_reset();
        else begin @(posedge clk_i); #1; end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        logic [31:0] word_v;
        op_t o;
        bit ackseen;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom());
            ref_mem[i] = mem_arr[i];
        end
        rd_q = 8'h00;
        bus.req0_i = 0; bus.we0_i = 0; bus.size0_i = 0; bus.uns0_i = 0; bus.addr0_i = 0; bus.wdata0_i = 0;
        bus.req1_i = 0; bus.we1_i = 0; bus.size1_i = 0; bus.uns1_i = 0; bus.addr1_i = 0; bus.wdata1_i = 0;
        rst_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        check_reset_outputs("rst");
        rst_i = 1'b0;
        last_model = 1'b1;

        // Word store of DEADBEEF at 0x10000.
        q0.push_back('{1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF});
        run_scn("wst");
        word_v = 32'hDEAD_BEEF;
        if (got_ev.size() > 0) check("wst_lat", got_ev[0].c - scn_t0, 5);
        for (int i = 0; i < 4; i++) if (wlog.size() > i) begin
            check($sformatf("wst_lit_a%0d", i), wlog[i].a, 32'h0001_0000 + 32'(i));
            check($sformatf("wst_lit_d%0d", i), 32'(wlog[i].d), 32'(word_v[8*i +: 8]));
            check($sformatf("wst_lit_c%0d", i), wlog[i].c - scn_t0, 32'(1 + i));
        end

        // 0x80 at 0x10000, 0xFF at 0x10001, then signed half and unsigned byte loads.
        q0.push_back('{1'b1, 2'b01, 1'b0, 32'h0001_0000, 32'h0000_FF80});
        run_scn("prep");
        q0.push_back('{1'b0, 2'b01, 1'b0, 32'h0001_0000, 32'h0});
        run_scn("hld");
        if (got_ev.size() > 0) begin
            check("hld_lit", got_ev[0].rd, 32'hFFFF_FF80);
            check("hld_lat", got_ev[0].c - scn_t0, 4);
        end
        q0.push_back('{1'b0, 2'b00, 1'b1, 32'h0001_0000, 32'h0});
        run_scn("bld");
        if (got_ev.size() > 0) begin
            check("bld_lit", got_ev[0].rd, 32'h0000_0080);
            check("bld_lat", got_ev[0].c - scn_t0, 3);
        end

        // Tie right after reset, then port 0 re-requesting against a waiting port 1.
        do_reset();
        q0.push_back('{1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0});
        q1.push_back('{1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0});
        run_scn("tie");
        if (got_ev.size() > 1) begin
            check("tie_first", 32'(got_ev[0].p), 0);
            check("tie_lat0", got_ev[0].c - scn_t0, 6);
            check("tie_second", 32'(got_ev[1].p), 1);
            check("tie_gap", got_ev[1].c - got_ev[0].c, 7);
        end
        q0.push_back('{1'b0, 2'b10, 1'b1, 32'h0001_0008, 32'h0});
        q0.push_back('{1'b0, 2'b00, 1'b0, 32'h0001_0001, 32'h0});
        q1.push_back('{1'b0, 2'b01, 1'b1, 32'h0001_0002, 32'h0});
        run_scn("retie");
        if (got_ev.size() > 2) begin
            check("retie_p0", 32'(got_ev[0].p), 0);
            check("retie_p1", 32'(got_ev[1].p), 1);
            check("retie_p2", 32'(got_ev[2].p), 0);
        end

        // Reset during beat 2 of a word store.
        o = '{1'b1, 2'b10, 1'b0, 32'h0002_0040, 32'h1234_5678};
        wlog.delete();
        ackseen = 1'b0;
        present(1'b0, o);
        repeat (3) begin @(posedge clk_i); #1; if (bus.ack0_o) ackseen = 1'b1; end
        check("mid_beat2_addr", bus.mem_addr_o, 32'h0002_0042);
        rst_i = 1'b1;
        #1;
        check("mid_wr_gated", 32'(bus.mem_wr_en_o), 0);
        @(posedge clk_i); #1;
        bus.req0_i = 1'b0;
        check_reset_outputs("mid");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        last_model = 1'b1;
        repeat (8) begin @(posedge clk_i); #1; if (bus.ack0_o || bus.ack1_o) ackseen = 1'b1; end
        check("mid_noack", 32'(ackseen), 0);
        check("mid_nwr", wlog.size(), 2);
        if (wlog.size() > 1) begin
            check("mid_w0", {wlog[0].a[7:0], wlog[0].d}, 16'h4078);
            check("mid_w1", {wlog[1].a[7:0], wlog[1].d}, 16'h4156);
        end
        ref_mem[8'h40] = 8'h78;
        ref_mem[8'h41] = 8'h56;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        q1.push_back('{1'b1, 2'b10, 1'b0, 32'h0001_0002, 32'hCAFE_F00D});
        run_scn("mis");
        check("mis_nwr_lit", wlog.size(), 0);
        if (got_ev.size() > 0) begin
            check("mis_lat", got_ev[0].c - scn_t0, 1);
            check("mis_err", 32'(got_ev[0].er), 1);
            check("mis_port", 32'(got_ev[0].p), 1);
        end
`else
        q0.push_back('{1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_A55A});
        run_scn("wrap");
        if (wlog.size() > 1) begin
            check("wrap_a0", wlog[0].a, 32'hFFFF_FFFF);
            check("wrap_a1", wlog[1].a, 32'h0000_0000);
            check("wrap_d1", 32'(wlog[1].d), 32'h0000_00A5);
        end
`endif

        for (int s = 0; s < 40; s++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            repeat (n0) q0.push_back(rand_op());
            repeat (n1) q1.push_back(rand_op());
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
            run_scn($sformatf("rnd%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
